// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time program loader, the writer side of the instruction path.
//
// It accepts a framed byte stream over a valid/ready handshake, builds 16-bit
// little-endian instruction words and writes them one by one into instruction
// memory, starting at BASE_ADDR. The core stays in hold until a complete image
// has been stored, its checksum matches and every opcode in it is legal.
//
// Frame: LEN_LO, LEN_HI (word count N), N x {lo, hi}, CSUM (XOR of payload bytes).
//
// Optional build macro: LOADER_OPCODE_CHECK_EN
//   defined   : a word with opcode instr[15:12] > 4'b1011 aborts the load (err_code 10)
//   undefined : every word is written, whatever its opcode
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               single-cycle pulse that arms a load (from IDLE, DONE or ERROR)
//   rx_data, rx_valid   incoming stream byte and its valid flag
//   rx_ready            loader can take a byte this cycle
//   imem_we             one-cycle write strobe per word
//   imem_addr           write address (BASE_ADDR + word index)
//   imem_wdata          write data {hi_byte, lo_byte}
//   core_hold           keeps the core stalled; low only once the image is verified
//   done, error         load verified / load aborted
//   err_code            01 length overflow, 10 illegal opcode, 11 checksum mismatch
//   words_loaded        words written during the current load
module instr_mem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI,
    S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  // Largest word count that still fits between BASE_ADDR and the top of memory.
  localparam int               MAX_N   = (1 << ADDR_W) - BASE_ADDR;
  localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   count_q, count_d;   // word index; equals words written so far
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        err_q, err_d;

  logic              accept;
  logic [15:0]       n_full;
  logic              opc_illegal;

  assign n_full = {rx_data, len_lo_q};

`ifdef LOADER_OPCODE_CHECK_EN
  localparam logic [3:0] MAX_OPC = 4'b1011;
  assign opc_illegal = (rx_data[7:4] > MAX_OPC);
`else
  assign opc_illegal = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    n_d       = n_q;
    lo_d      = lo_q;
    csum_d    = csum_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rx_ready  = 1'b0;
    imem_we   = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    core_hold = 1'b1;
    accept    = 1'b0;

    unique case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM: rx_ready = 1'b1;
      default: rx_ready = 1'b0;
    endcase
    accept = rx_valid && rx_ready;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERROR);
        core_hold = (state_q != S_DONE);
        if (start) begin
          state_d = S_LEN_LO;
          count_d = '0;
          csum_d  = '0;
          err_d   = 2'b00;
        end
      end
      S_LEN_LO: if (accept) begin
        len_lo_d = rx_data;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (accept) begin
        n_d = (ADDR_W+1)'(n_full);
        if (int'(n_full) > MAX_N) begin
          state_d = S_ERROR;
          err_d   = 2'b01;
        end else if (n_full == 16'd0) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: if (accept) begin
        lo_d    = rx_data;
        csum_d  = csum_q ^ rx_data;
        state_d = S_DATA_HI;
      end
      S_DATA_HI: if (accept) begin
        csum_d = csum_q ^ rx_data;
        if (opc_illegal) begin
          state_d = S_ERROR;
          err_d   = 2'b10;
        end else begin
          // Address and data are registered here so they are valid in the WRITE cycle.
          addr_d  = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];
          wdata_d = {rx_data, lo_q};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        count_d = count_q + CNT_ONE;
        state_d = ((count_q + CNT_ONE) == n_q) ? S_CSUM : S_DATA_LO;
      end
      S_CSUM: if (accept) begin
        if (rx_data == csum_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERROR;
          err_d   = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      n_q      <= '0;
      lo_q     <= '0;
      csum_q   <= '0;
      count_q  <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      wdata_q  <= '0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      n_q      <= n_d;
      lo_q     <= lo_d;
      csum_q   <= csum_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign err_code     = err_q;
  assign words_loaded = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: frame-level reference model, one per-cycle
// compare step, directed frames from the test plan plus randomized frames.
module tb_instr_mem_loader;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 1 << ADDR_W;

`ifdef LOADER_OPCODE_CHECK_EN
  localparam bit OPC_CHK = 1'b1;
`else
  localparam bit OPC_CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, imem_we, core_hold, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Memory image as written by the DUT, plus a write counter.
  logic [15:0] mem [DEPTH];
  int          wr_count = 0;

  // Frame under construction and its analysis.
  logic [7:0]  fr [$];
  int          a_need, a_res;
  logic [15:0] a_wd [$];

  // Model of the running load (latched at start).
  bit                m_active, m_wr_now;
  int                m_pos, m_words, m_need, m_res;
  logic [15:0]       m_wd [$];
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_wdata;

  // Works out what the frame must do: bytes consumed, result code, words written.
  task automatic analyze();
    int         n;
    logic [7:0] cs, lo, hi;
    a_wd.delete();
    cs = 8'h00;
    n  = int'({fr[1], fr[0]});
    if (n > DEPTH - BASE_ADDR) begin
      a_need = 2; a_res = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      lo = fr[2+2*k];
      hi = fr[3+2*k];
      cs = cs ^ lo ^ hi;
      if (OPC_CHK && hi[7:4] > 4'd11) begin
        a_need = 4 + 2*k; a_res = 2;
        return;
      end
      a_wd.push_back({hi, lo});
    end
    a_need = 3 + 2*n;
    a_res  = (fr[2+2*n] == cs) ? 0 : 3;
  endtask

  function automatic bit m_term();
    return m_active && (m_pos == m_need) && !m_wr_now;
  endfunction

  function automatic bit m_ready();
    return m_active && (m_pos < m_need) && !m_wr_now;
  endfunction

  task automatic model_reset();
    m_active = 0; m_wr_now = 0; m_pos = 0; m_words = 0;
    m_need = 0; m_res = 0; m_wd.delete();
    m_addr = ADDR_W'(BASE_ADDR); m_wdata = 16'h0000;
  endtask

  task automatic model_update(input bit st, input bit rst, input bit v);
    bit term, rdy, nxt_wr;
    int p, k;
    if (rst) begin
      model_reset();
      return;
    end
    term   = m_term();
    rdy    = m_ready();
    nxt_wr = 0;
    if (m_wr_now) begin
      m_words++;
    end else if (rdy && v) begin
      p = m_pos;
      m_pos++;
      k = (p - 2) / 2;
      if (p >= 2 && ((p - 2) % 2) == 1 && k < m_wd.size()) begin
        m_addr  = ADDR_W'(BASE_ADDR + k);
        m_wdata = m_wd[k];
        nxt_wr  = 1;
      end
    end
    if (st && (!m_active || term)) begin
      m_active = 1; m_pos = 0; m_words = 0;
      m_need = a_need; m_res = a_res; m_wd = a_wd;
    end
    m_wr_now = nxt_wr;
  endtask

  // The single per-cycle compare of DUT outputs against the model.
  task automatic compare();
    bit term;
    term = m_term();
    check("rx_ready",     rx_ready,     m_ready());
    check("imem_we",      imem_we,      m_wr_now);
    check("imem_addr",    imem_addr,    m_addr);
    check("imem_wdata",   imem_wdata,   m_wdata);
    check("words_loaded", words_loaded, m_words);
    check("done",         done,         term && m_res == 0);
    check("error",        error,        term && m_res != 0);
    check("err_code",     err_code,     (term && m_res != 0) ? m_res : 0);
    check("core_hold",    core_hold,    !(term && m_res == 0));
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      wr_count++;
    end
  endtask

  // One clock: compare at the falling edge, then drive inputs for the next rising edge.
  task automatic cycle(input bit st, input bit rst, input bit v, input logic [7:0] d);
    compare();
    start = st; reset = rst; rx_valid = v; rx_data = d;
    model_update(st, rst, v);
    @(negedge clk);
  endtask

  // vmode: 0 always valid, 1 valid every other cycle, 2 random valid.
  task automatic run_frame(input int vmode, input bit poke, input bit abort);
    bit         v, st, r, poked;
    logic [7:0] d;
    poked = 0;
    analyze();
    cycle(1, 0, 0, 8'h00);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (m_term()) break;
      case (vmode)
        0:       v = 1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d  = (m_pos < fr.size()) ? fr[m_pos] : 8'($urandom);
      st = poke && !poked && m_active && m_pos == 2 && !m_wr_now;
      if (st) poked = 1;
      r = abort && m_words == 1;
      cycle(st, r, v, d);
      if (r) break;
    end
    if (!abort) check("frame_timeout", m_term(), 1);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
  endtask

  task automatic rand_frame(input int n, input bit bad_csum, input bit legal_only);
    logic [7:0] cs, lo, hi;
    fr = {8'(n), 8'(n >> 8)};
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      lo = 8'($urandom);
      hi = legal_only ? {4'($urandom_range(0, 11)), 4'($urandom)} : 8'($urandom);
      cs = cs ^ lo ^ hi;
      fr.push_back(lo);
      fr.push_back(hi);
    end
    fr.push_back(bad_csum ? (cs ^ 8'($urandom_range(1, 255))) : cs);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int wc0;

  initial begin
    reset = 1; start = 0; rx_valid = 0; rx_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
    repeat (3) @(negedge clk);
    model_reset();
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    check("reset_core_hold", core_hold, 1);
    check("reset_addr", imem_addr, BASE_ADDR);

    // Pin the model against hand-worked values.
    fr = {8'h02, 8'h00, 8'h05, 8'h21, 8'h33, 8'h3A, 8'h2D};
    analyze();
    check("model_need", a_need, 7);
    check("model_res", a_res, 0);
    check("model_w0", a_wd[0], 16'h2105);
    check("model_w1", a_wd[1], 16'h3A33);

    // Two-word image, full rate.
    wc0 = wr_count;
    run_frame(0, 0, 0);
    check("t1_mem0", mem[0], 16'h2105);
    check("t1_mem1", mem[1], 16'h3A33);
    check("t1_done", done, 1);
    check("t1_hold", core_hold, 0);
    check("t1_words", words_loaded, 2);
    check("t1_error", error, 0);
    check("t1_writes", wr_count - wc0, 2);

    // Same image, rx_valid every other cycle, restarted from DONE.
    mem[0] = 16'hDEAD; mem[1] = 16'hDEAD;
    wc0 = wr_count;
    run_frame(1, 0, 0);
    check("t1b_mem0", mem[0], 16'h2105);
    check("t1b_mem1", mem[1], 16'h3A33);
    check("t1b_done", done, 1);
    check("t1b_writes", wr_count - wc0, 2);

    // Opcode 0xC.
    fr = {8'h01, 8'h00, 8'h00, 8'hC0, 8'hC0};
    mem[0] = 16'hDEAD;
    wc0 = wr_count;
    run_frame(0, 0, 0);
`ifdef LOADER_OPCODE_CHECK_EN
    check("t2_writes", wr_count - wc0, 0);
    check("t2_error", error, 1);
    check("t2_code", err_code, 2);
    check("t2_hold", core_hold, 1);
    check("t2_ready", rx_ready, 0);
`else
    check("t2_mem0", mem[0], 16'hC000);
    check("t2_done", done, 1);
`endif

    // Checksum mismatch after one good word.
    fr = {8'h01, 8'h00, 8'h34, 8'h12, 8'hFF};
    run_frame(0, 0, 0);
    check("t3_mem0", mem[0], 16'h1234);
    check("t3_error", error, 1);
    check("t3_code", err_code, 3);
    check("t3_done", done, 0);
    check("t3_hold", core_hold, 1);

    // Length overflow, N = 257.
    fr = {8'h01, 8'h01};
    wc0 = wr_count;
    run_frame(0, 0, 0);
    check("t4_code", err_code, 1);
    check("t4_error", error, 1);
    check("t4_writes", wr_count - wc0, 0);

    // Empty image.
    fr = {8'h00, 8'h00, 8'h00};
    wc0 = wr_count;
    run_frame(2, 0, 0);
    check("t4b_done", done, 1);
    check("t4b_words", words_loaded, 0);
    check("t4b_writes", wr_count - wc0, 0);

    // start during DATA_LO is ignored.
    fr = {8'h02, 8'h00, 8'h05, 8'h21, 8'h33, 8'h3A, 8'h2D};
    run_frame(0, 1, 0);
    check("t5_done", done, 1);
    check("t5_words", words_loaded, 2);

    // reset after the first word lands.
    run_frame(2, 0, 1);
    check("t6_ready", rx_ready, 0);
    check("t6_hold", core_hold, 1);
    check("t6_words", words_loaded, 0);
    check("t6_addr", imem_addr, BASE_ADDR);
    check("t6_wdata", imem_wdata, 0);
    check("t6_mem0", mem[0], 16'h2105);

    // Largest image that fits, and a far overflow.
    rand_frame(DEPTH - BASE_ADDR, 0, 1);
    run_frame(2, 0, 0);
    check("full_done", done, 1);
    check("full_words", words_loaded, DEPTH - BASE_ADDR);
    fr = {8'hFF, 8'hFF};
    run_frame(0, 0, 0);
    check("ovf_code", err_code, 1);

    // Randomized frames.
    for (int t = 0; t < 40; t++) begin
      rand_frame($urandom_range(0, 6), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
      run_frame($urandom_range(0, 2), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
